// File: rtl/riscv_pkg.sv
// Shared definitions for the single-core RISC-V datapath: decoder opcodes
// and the data-memory responder state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous word RAM with registered read (read-before-write).
// Contents are intentionally not reset.
module data_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    q <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches a load/store, stalls the core for
// LATENCY busy cycles, then pulses ready for one cycle with the result.
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              ready,
  output logic              misaligned
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              op_write;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req;
  logic [IDX_W-1:0]  ram_idx;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  logic              unused_addr_bits;

  assign req              = memRead | memWrite;
  assign unused_addr_bits = ^addr[ADDR_W-1:IDX_W+2];

  // In IDLE the RAM is addressed straight from the request so that its
  // registered output is already valid during the first BUSY cycle.
  assign ram_idx = (state == IDLE) ? addr[IDX_W+1:2] : idx_q;
  assign ram_we  = rst_n && (state == BUSY) && (cnt == 4'd0) && op_write;
  assign stall   = ((state == IDLE) && req) || (state == BUSY);

  data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .q     (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_write   <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata      <= '0;
      ready      <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      ready      <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            op_write <= memWrite;
            idx_q    <= addr[IDX_W+1:2];
            wdata_q  <= wdata;
            cnt      <= 4'(LATENCY - 1);
            if (addr[1:0] != 2'b00) begin
              state      <= DONE;
              ready      <= 1'b1;
              misaligned <= 1'b1;
              rdata      <= '0;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            ready <= 1'b1;
            if (!op_write) begin
              rdata <= ram_q;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=2, DEPTH=256).
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        ready;
  logic        misaligned;

  int n_checks = 0;
  int n_errors = 0;

  data_mem_responder #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .DEPTH   (256),
    .LATENCY (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .ready      (ready),
    .misaligned (misaligned)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at the current negedge (cycle 0), hold strobes until
  // ready, then check the completion cycle, flags, data and the idle cycle after.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_done, input logic exp_mis,
                        input logic chk_data, input logic [31:0] exp_data);
    int done_cyc;
    done_cyc = -1;
    memRead  = rd;
    memWrite = wr;
    addr     = a;
    wdata    = d;
    #1;
    check({tag, "_stall_c0"}, 32'(stall), 32'd1);
    check({tag, "_ready_c0"}, 32'(ready), 32'd0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (ready) begin
        done_cyc = c;
        break;
      end
      check({tag, "_stall_busy"}, 32'(stall), 32'd1);
    end
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    check({tag, "_misaligned"}, 32'(misaligned), 32'(exp_mis));
    if (chk_data) check({tag, "_rdata"}, rdata, exp_data);
    memRead  = 1'b0;
    memWrite = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(ready), 32'd0);
    check({tag, "_mis_after"}, 32'(misaligned), 32'd0);
    if (chk_data) check({tag, "_rdata_held"}, rdata, exp_data);
  endtask

  initial begin
    rst_n    = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    addr     = '0;
    wdata    = '0;
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_stall_idle", 32'(stall), 32'd0);
    memRead = 1'b1;
    #1;
    check("rst_stall_comb", 32'(stall), 32'd1);
    memRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access("st_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 1'b0, 32'h0);
    access("ld_10", 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);
    access("ld_13", 1'b1, 1'b0, 32'h13, 32'h0, 1, 1'b1, 1'b1, 32'h0);
    access("ld_10b", 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);
    access("st_11", 1'b0, 1'b1, 32'h11, 32'h0BADF00D, 1, 1'b1, 1'b0, 32'h0);
    access("ld_10c", 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);

    // reset during BUSY aborts the store
    memWrite = 1'b1;
    addr     = 32'h10;
    wdata    = 32'hFFFFFFFF;
    @(negedge clk);
    check("abort_stall_c1", 32'(stall), 32'd1);
    check("abort_ready_c1", 32'(ready), 32'd0);
    rst_n    = 1'b0;
    memWrite = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_mis", 32'(misaligned), 32'd0);
    @(negedge clk);
    check("abort_ready_c3", 32'(ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    access("ld_after_abort", 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);

    access("st_410", 1'b0, 1'b1, 32'h410, 32'h12345678, 3, 1'b0, 1'b0, 32'h0);
    access("ld_010_wrap", 1'b1, 1'b0, 32'h010, 32'h0, 3, 1'b0, 1'b1, 32'h12345678);
    access("both_20", 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 3, 1'b0, 1'b0, 32'h0);
    access("ld_20", 1'b1, 1'b0, 32'h20, 32'h0, 3, 1'b0, 1'b1, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the single-core RISC-V datapath. It services the `memRead`/`memWrite` strobes that the main decoder raises for loads (opcode 0000011) and stores (opcode 0100011). It performs a word access on an internal RAM after a configurable latency and holds the core with `stall` until the access completes. It sits between the EX-stage address/store-data outputs and the write-back mux driven by `memToReg`.

## Interface
- `DATA_W`, 32, data word width
- `ADDR_W`, 32, byte-address width
- `DEPTH`, 256, RAM depth in words; must be a power of two
- `LATENCY`, 2, number of BUSY cycles per access; legal range 1..15

- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `memRead`  in  1  load request from the decoder
- `memWrite`  in  1  store request from the decoder
- `addr`  in  ADDR_W  byte address (ALU result)
- `wdata`  in  DATA_W  store data (rs2)
- `rdata`  out  DATA_W  load data; valid while `ready`=1, held afterwards
- `stall`  out  1  freeze PC and pipeline registers
- `ready`  out  1  one-cycle completion pulse
- `misaligned`  out  1  error flag, valid with `ready`

## Operation
- Single clock and single reset: synchronous, active-low `rst_n`.
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - If `memRead` or `memWrite` is 1, latch `addr`, `wdata` and the op.
  - Load a down-counter with LATENCY-1 and go to BUSY.
  - If both strobes are 1, the op is a write.
- **Misaligned request** (`addr[1:0]` != 0)
  - Go IDLE -> DONE directly, skipping BUSY.
  - No RAM access; the write is suppressed.
  - `rdata` is driven to 0 and `misaligned`=1 for the DONE cycle.
- **Word index**: `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- **BUSY**
  - Decrement the counter each cycle.
  - When the counter is 0, go to DONE.
  - A write commits to RAM on that same edge.
  - A read captures `RAM[index]` into `rdata` on that same edge.
- **DONE**
  - `ready`=1 and `stall`=0. The pipeline advances at the end of this cycle.
  - Strobes seen during DONE belong to the completing instruction and are ignored.
  - Always go to IDLE next.
- **`stall` (combinational)**: 1 when (IDLE and (`memRead` or `memWrite`)) or when in BUSY; otherwise 0.
- Strobe changes while in BUSY are ignored, because the request is latched.

## Timing
- A request first seen in IDLE at cycle 0 produces:
  - BUSY in cycles 1..LATENCY;
  - DONE in cycle LATENCY+1;
  - `stall`=1 in cycles 0..LATENCY.
- Misaligned request: DONE in cycle 1; `stall`=1 in cycle 0 only.
- Back-to-back: after DONE, a new request can be accepted at the next IDLE cycle. Minimum spacing between accepts is LATENCY+2 cycles.
- Read-after-write to the same word returns the new data, because the write commits before the later request is accepted.
- Reset values:
  - state = IDLE, counter = 0;
  - `rdata` = 0, `ready` = 0, `misaligned` = 0;
  - `stall` follows its combinational rule.
- RAM contents are not reset.
- Reset asserted during BUSY aborts the access: a pending write is not committed and no `ready` pulse is produced.
- `rdata` holds its last value until the next DONE.

## Structure
- Shared package `riscv_pkg` holds:
  - the opcode constants `OP_LOAD`=7'b0000011 and `OP_STORE`=7'b0100011;
  - the FSM state enum `dmem_state_t` {IDLE, BUSY, DONE}.
- Sub-module `data_ram`: single-port synchronous RAM, DEPTH x DATA_W, with write-enable, index, wdata and registered read. `data_mem_responder` owns the FSM, counter, latches and error logic.

## Test plan
- Reset, then store `wdata`=0xDEADBEEF to `addr`=0x10 with LATENCY=2 -> `stall` high in cycles 0-2, `ready` in cycle 3, `misaligned`=0.
- Load from 0x10 immediately after that store -> `rdata`=0xDEADBEEF with `ready` in cycle 3.
- Load from 0x13 -> `ready` in cycle 1, `misaligned`=1, `rdata`=0; a following aligned load of 0x10 still returns 0xDEADBEEF.
- Store 0x12345678 to 0x410 with DEPTH=256 -> a load from 0x010 returns 0x12345678 (address wrap).
- `memRead`=`memWrite`=1 with `addr`=0x20 and `wdata`=0xA5A5A5A5 -> treated as a store; a later load of 0x20 returns 0xA5A5A5A5.
- Store 0xFFFFFFFF to 0x10, drop `rst_n` in cycle 1 (BUSY) -> no `ready` pulse, all outputs 0 next cycle; a later load of 0x10 returns the old value 0xDEADBEEF.
